// File: rtl/prescaler_timer.sv
`default_nettype none
// ============================================================================
//  Module      : prescaler_timer
//  Description : Prescaled period timer. A prescaler wraps every (psc+1)
//                enabled cycles and emits a tick; each tick advances a
//                period counter that either reloads (periodic) or stops in
//                DONE (one-shot). It is the shared time base for PWM, UART
//                baud and debounce peripherals.
//  Optional    : define PRESCALER_TIMER_PWM_EN to add the cmp input and the
//                registered pwm_out output.
//  Ports       : clk      - system clock, rising edge
//                reset    - asynchronous active-low reset
//                en       - count enable, low freezes prescaler and counter
//                start    - pulse: latch settings, clear counters, run
//                stop     - pulse: abort to IDLE (wins over start)
//                mode     - 0 periodic, 1 one-shot (sampled at start)
//                psc      - prescale value, tick every psc+1 enabled cycles
//                period   - terminal count of the period counter
//                cmp      - PWM compare value (PWM build only)
//                tick     - 1-cycle prescaler wrap pulse
//                expire   - 1-cycle terminal-count pulse
//                busy     - high while running
//                cnt      - current period count
//                pwm_out  - PWM output (PWM build only)
//  Revision    : 1.0 - initial release
// ============================================================================
module prescaler_timer #(
    parameter int PSC_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [PSC_W-1:0] psc,
    input  logic [CNT_W-1:0] period,
    output logic             tick,
    output logic             expire,
    output logic             busy,
    output logic [CNT_W-1:0] cnt
`ifdef PRESCALER_TIMER_PWM_EN
    ,
    input  logic [CNT_W-1:0] cmp,
    output logic             pwm_out
`endif
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [PSC_W-1:0] r_pcnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             r_expire;
    logic [PSC_W-1:0] r_psc_q;
    logic [CNT_W-1:0] r_period_q;
    logic             r_mode_q;

    logic [1:0]       w_state_next;
    logic [PSC_W-1:0] w_pcnt_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_tick_next;
    logic             w_expire_next;
    logic [PSC_W-1:0] w_psc_next;
    logic [CNT_W-1:0] w_period_next;
    logic             w_mode_next;

`ifdef PRESCALER_TIMER_PWM_EN
    logic [CNT_W-1:0] r_cmp_q;
    logic             r_pwm;
    logic [CNT_W-1:0] w_cmp_next;
    logic             w_pwm_next;
`endif

    // Next-state computation for the whole timer; the register block below
    // only captures these values, which keeps every output registered.
    always_comb begin
        w_state_next  = r_state;
        w_pcnt_next   = r_pcnt;
        w_cnt_next    = r_cnt;
        w_tick_next   = 1'b0;
        w_expire_next = 1'b0;
        w_psc_next    = r_psc_q;
        w_period_next = r_period_q;
        w_mode_next   = r_mode_q;
`ifdef PRESCALER_TIMER_PWM_EN
        w_cmp_next    = r_cmp_q;
`endif
        if (stop) begin
            w_state_next = c_ST_IDLE;
            w_pcnt_next  = '0;
            w_cnt_next   = '0;
        end else if (start) begin
            // start from any state restarts the whole sequence
            w_state_next  = c_ST_RUN;
            w_pcnt_next   = '0;
            w_cnt_next    = '0;
            w_psc_next    = psc;
            w_period_next = period;
            w_mode_next   = mode;
`ifdef PRESCALER_TIMER_PWM_EN
            w_cmp_next    = cmp;
`endif
        end else begin
            case (r_state)
                c_ST_RUN: begin
                    if (en) begin
                        if (r_pcnt == r_psc_q) begin
                            w_pcnt_next = '0;
                            w_tick_next = 1'b1;
                            if (r_cnt == r_period_q) begin
                                w_expire_next = 1'b1;
                                if (r_mode_q) begin
                                    // one-shot: cnt stays at the terminal value
                                    w_state_next = c_ST_DONE;
                                end else begin
                                    // periodic: new settings take effect only
                                    // at the period boundary
                                    w_cnt_next    = '0;
                                    w_psc_next    = psc;
                                    w_period_next = period;
`ifdef PRESCALER_TIMER_PWM_EN
                                    w_cmp_next    = cmp;
`endif
                                end
                            end else begin
                                w_cnt_next = r_cnt + CNT_W'(1);
                            end
                        end else begin
                            w_pcnt_next = r_pcnt + PSC_W'(1);
                        end
                    end
                end
                c_ST_DONE: begin
                    w_pcnt_next = '0;
                    w_cnt_next  = r_period_q;
                end
                default: begin
                    w_state_next = c_ST_IDLE;
                    w_pcnt_next  = '0;
                    w_cnt_next   = '0;
                end
            endcase
        end
`ifdef PRESCALER_TIMER_PWM_EN
        // Compare against the count the counter is about to hold so the
        // PWM edge lines up with the cnt value seen on the same cycle.
        w_pwm_next = (w_state_next == c_ST_RUN) && (w_cnt_next < w_cmp_next);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_pcnt     <= '0;
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_expire   <= 1'b0;
            r_psc_q    <= '0;
            r_period_q <= '0;
            r_mode_q   <= 1'b0;
`ifdef PRESCALER_TIMER_PWM_EN
            r_cmp_q    <= '0;
            r_pwm      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_pcnt     <= w_pcnt_next;
            r_cnt      <= w_cnt_next;
            r_tick     <= w_tick_next;
            r_expire   <= w_expire_next;
            r_psc_q    <= w_psc_next;
            r_period_q <= w_period_next;
            r_mode_q   <= w_mode_next;
`ifdef PRESCALER_TIMER_PWM_EN
            r_cmp_q    <= w_cmp_next;
            r_pwm      <= w_pwm_next;
`endif
        end
    end

    assign tick   = r_tick;
    assign expire = r_expire;
    assign busy   = (r_state == c_ST_RUN);
    assign cnt    = r_cnt;
`ifdef PRESCALER_TIMER_PWM_EN
    assign pwm_out = r_pwm;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prescaler_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prescaler_timer
//  Description : Directed self-checking bench for prescaler_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prescaler_timer;

    localparam int PSC_W = 8;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             en;
    logic             start;
    logic             stop;
    logic             mode;
    logic [PSC_W-1:0] psc;
    logic [CNT_W-1:0] period;
    logic             tick;
    logic             expire;
    logic             busy;
    logic [CNT_W-1:0] cnt;
`ifdef PRESCALER_TIMER_PWM_EN
    logic [CNT_W-1:0] cmp;
    logic             pwm_out;
`endif

    int checks;
    int errors;

    prescaler_timer #(.PSC_W(PSC_W), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .start  (start),
        .stop   (stop),
        .mode   (mode),
        .psc    (psc),
        .period (period),
        .tick   (tick),
        .expire (expire),
        .busy   (busy),
`ifdef PRESCALER_TIMER_PWM_EN
        .cnt    (cnt),
        .cmp    (cmp),
        .pwm_out(pwm_out)
`else
        .cnt    (cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge and settle 1 ns after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input int p, input int per);
        mode   = m;
        psc    = PSC_W'(p);
        period = CNT_W'(per);
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({tick, expire, busy} !== 3'b000 || cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: tick=%b expire=%b busy=%b cnt=%0d, want 0 0 0 0",
                     tick, expire, busy, cnt);
        end
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || cnt !== '0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b cnt=%0d, want 0 0", busy, cnt);
        end
    endtask

    // psc=3 period=4: tick every 4 edges, cnt=(n/4)%5, expire every 20 edges
    task automatic test_periodic();
        en = 1'b1;
        do_start(1'b0, 3, 4);
        checks++;
        if (busy !== 1'b1 || cnt !== '0 || tick !== 1'b0 || expire !== 1'b0) begin
            errors++;
            $display("FAIL periodic_start: busy=%b cnt=%0d tick=%b expire=%b, want 1 0 0 0",
                     busy, cnt, tick, expire);
        end
        for (int n = 1; n <= 40; n++) begin
            step();
            checks++;
            if (tick !== ((n % 4) == 0)) begin
                errors++;
                $display("FAIL periodic_tick edge %0d: got %b want %b", n, tick, (n % 4) == 0);
            end
            checks++;
            if (expire !== ((n % 20) == 0)) begin
                errors++;
                $display("FAIL periodic_expire edge %0d: got %b want %b", n, expire, (n % 20) == 0);
            end
            checks++;
            if (cnt !== CNT_W'((n / 4) % 5)) begin
                errors++;
                $display("FAIL periodic_cnt edge %0d: got %0d want %0d", n, cnt, (n / 4) % 5);
            end
        end
    endtask

    // psc=0 period=2 one-shot: expire on edge 3, then DONE holding cnt=2
    task automatic test_oneshot();
        logic [CNT_W-1:0] exp_cnt [1:6];
        logic             exp_exp [1:6];
        logic             exp_bsy [1:6];
        exp_cnt = '{16'd1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2};
        exp_exp = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_bsy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        en = 1'b1;
        do_start(1'b1, 0, 2);
        for (int n = 1; n <= 6; n++) begin
            step();
            checks++;
            if (cnt !== exp_cnt[n] || expire !== exp_exp[n] || busy !== exp_bsy[n]) begin
                errors++;
                $display("FAIL oneshot edge %0d: cnt=%0d expire=%b busy=%b, want %0d %b %b",
                         n, cnt, expire, busy, exp_cnt[n], exp_exp[n], exp_bsy[n]);
            end
            if (n >= 4) begin
                checks++;
                if (tick !== 1'b0) begin
                    errors++;
                    $display("FAIL oneshot_done_tick edge %0d: got %b want 0", n, tick);
                end
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnt !== '0) begin
            errors++;
            $display("FAIL oneshot_stop: busy=%b cnt=%0d, want 0 0", busy, cnt);
        end
    endtask

    // en low for edges 11..15: everything freezes, expire moves from 20 to 25
    task automatic test_en_freeze();
        int e;
        e = 0;
        en = 1'b1;
        do_start(1'b0, 3, 4);
        for (int n = 1; n <= 30; n++) begin
            en = !(n >= 11 && n <= 15);
            step();
            if (en) e++;
            checks++;
            if (expire !== (en && (e % 20) == 0)) begin
                errors++;
                $display("FAIL freeze_expire edge %0d: got %b want %b", n, expire,
                         en && (e % 20) == 0);
            end
            checks++;
            if (cnt !== CNT_W'((e / 4) % 5)) begin
                errors++;
                $display("FAIL freeze_cnt edge %0d: got %0d want %0d", n, cnt, (e / 4) % 5);
            end
            if (!en) begin
                checks++;
                if (tick !== 1'b0) begin
                    errors++;
                    $display("FAIL freeze_tick edge %0d: got %b want 0", n, tick);
                end
            end
        end
        en = 1'b1;
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || cnt !== '0 || tick !== 1'b0 || expire !== 1'b0) begin
            errors++;
            $display("FAIL freeze_stop: busy=%b cnt=%0d tick=%b expire=%b, want 0 0 0 0",
                     busy, cnt, tick, expire);
        end
    endtask

    // period 4 -> 1 after edge 2: current period still ends at cnt=4
    task automatic test_period_change();
        logic [CNT_W-1:0] exp_cnt [1:11];
        logic             exp_exp [1:11];
        exp_cnt = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1, 16'd0};
        exp_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        en = 1'b1;
        do_start(1'b0, 0, 4);
        for (int n = 1; n <= 11; n++) begin
            if (n == 3) period = CNT_W'(1);
            step();
            checks++;
            if (cnt !== exp_cnt[n] || expire !== exp_exp[n]) begin
                errors++;
                $display("FAIL period_change edge %0d: cnt=%0d expire=%b, want %0d %b",
                         n, cnt, expire, exp_cnt[n], exp_exp[n]);
            end
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        do_start(1'b0, 3, 4);
        for (int n = 1; n <= 12; n++) step();
        checks++;
        if (tick !== 1'b1 || cnt !== CNT_W'(3) || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: tick=%b cnt=%0d busy=%b, want 1 3 1", tick, cnt, busy);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({tick, expire, busy} !== 3'b000 || cnt !== '0) begin
            errors++;
            $display("FAIL async_reset: tick=%b expire=%b busy=%b cnt=%0d, want 0 0 0 0",
                     tick, expire, busy, cnt);
        end
        reset = 1'b1;
        step();
        mode   = 1'b0;
        psc    = PSC_W'(0);
        period = CNT_W'(2);
        start  = 1'b1;
        stop   = 1'b1;
        step();
        start  = 1'b0;
        stop   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (busy !== 1'b0 || cnt !== '0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL start_stop_same edge %0d: busy=%b cnt=%0d tick=%b, want 0 0 0",
                         n, busy, cnt, tick);
            end
            step();
        end
    endtask

    // restart while running clears the counters immediately
    task automatic test_back_to_back();
        en = 1'b1;
        do_start(1'b0, 0, 7);
        for (int n = 1; n <= 5; n++) step();
        checks++;
        if (cnt !== CNT_W'(5)) begin
            errors++;
            $display("FAIL b2b_precount: got %0d want 5", cnt);
        end
        do_start(1'b0, 1, 7);
        checks++;
        if (cnt !== '0 || busy !== 1'b1 || tick !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: cnt=%0d busy=%b tick=%b, want 0 1 0", cnt, busy, tick);
        end
        step();
        step();
        checks++;
        if (cnt !== CNT_W'(1) || tick !== 1'b1) begin
            errors++;
            $display("FAIL b2b_new_psc: cnt=%0d tick=%b, want 1 1", cnt, tick);
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

`ifdef PRESCALER_TIMER_PWM_EN
    task automatic test_pwm();
        int highs;
        highs = 0;
        en  = 1'b1;
        cmp = CNT_W'(3);
        do_start(1'b0, 0, 9);
        for (int n = 0; n < 30; n++) begin
            if (n > 0) step();
            if (pwm_out === 1'b1) highs++;
            checks++;
            if (pwm_out !== ((n % 10) < 3)) begin
                errors++;
                $display("FAIL pwm_cmp3 edge %0d: got %b want %b", n, pwm_out, (n % 10) < 3);
            end
        end
        checks++;
        if (highs != 9) begin
            errors++;
            $display("FAIL pwm_duty: got %0d highs want 9", highs);
        end
        cmp = CNT_W'(0);
        do_start(1'b0, 0, 9);
        for (int n = 0; n < 20; n++) begin
            checks++;
            if (pwm_out !== 1'b0) begin
                errors++;
                $display("FAIL pwm_cmp0 edge %0d: got %b want 0", n, pwm_out);
            end
            step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL pwm_idle: got %b want 0", pwm_out);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        en     = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 1'b0;
        psc    = '0;
        period = '0;
`ifdef PRESCALER_TIMER_PWM_EN
        cmp    = '0;
`endif
        test_reset();
        test_periodic();
        stop = 1'b1;
        step();
        stop = 1'b0;
        test_oneshot();
        test_en_freeze();
        test_period_change();
        stop = 1'b1;
        step();
        stop = 1'b0;
        test_async_reset();
        test_back_to_back();
`ifdef PRESCALER_TIMER_PWM_EN
        test_pwm();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
